mc_controller: RTL and testbench

- Multicycle MIPS control unit. Moore FSM sequences the shared datapath (single memory, single ALU, IR/PC/A/B/ALUOut registers) over 3-5 cycles per instruction.
- Supersedes the single-cycle decoder for the multicycle core; it sits beside mc_datapath in the core top.
- Adds a memory-ready handshake so instruction and data accesses may stall.
- Keeps a retired-instruction counter.

---
 rtl/mc_pkg.sv | 70 +++++++
 rtl/mc_out_dec.sv | 89 ++++++++
 rtl/mc_controller.sv | 115 +++++++++++
 tb/tb_mc_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Optional BNE support is compiled in with MC_CTRL_BNE_EN.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef MC_CTRL_BNE_EN
    S_BNEEX   = 4'd12,
`endif
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       alu_wreg;
    logic       enable_wreg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) ||
         (op == OP_SW) || (op == OP_BEQ) ||
         (op == OP_ADDI) || (op == OP_J);
`ifdef MC_CTRL_BNE_EN
    ok = ok || (op == OP_BNE);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/mc_out_dec.sv
// Moore output decode for mc_controller, with memory-ready gating.
// BNEEX decode present only when MC_CTRL_BNE_EN is defined.
module mc_out_dec
  import mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  state_t     state_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  logic rdy;
  logic pc_write;
  logic branch;
  logic taken;

  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;

  always_comb begin
    ctrl_o   = '0;
    pc_write = 1'b0;
    branch   = 1'b0;
    taken    = 1'b0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = rdy;
        pc_write         = rdy;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.illegal   = ~op_legal(op_i);
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.alu_wreg    = 1'b1;
        ctrl_o.enable_wreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_o.reg_dst     = 1'b1;
        ctrl_o.enable_wreg = 1'b1;
      end
      S_BEQEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_src    = PC_ALUOUT;
        branch           = 1'b1;
        taken            = zero_i;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNEEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_src    = PC_ALUOUT;
        branch           = 1'b1;
        taken            = ~zero_i;
      end
`endif
      S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: ctrl_o.enable_wreg = 1'b1;
      S_JEX: begin
        ctrl_o.pc_src = PC_JUMP;
        pc_write      = 1'b1;
      end
      default: ;
    endcase
    ctrl_o.pc_en = pc_write | (branch & taken);
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory stall and retire counter.
// Optional BNE decode is enabled by defining MC_CTRL_BNE_EN.
module mc_controller
  import mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [5:0]       op_i6,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             iord_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_rtrd_o,
  output logic             alu_wreg_o,
  output logic             enable_wreg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o2,
  output logic [1:0]       alu_op_o2,
  output logic [1:0]       pc_src_o2,
  output logic             pc_en_o,
  output logic             illegal_op_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy;
  logic             retire;
  ctrl_t            ctrl;

  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op_i6 == OP_LW) || (op_i6 == OP_SW):
            state_d = S_MEMADR;
          op_i6 == OP_RTYPE: state_d = S_RTYPEEX;
          op_i6 == OP_BEQ:   state_d = S_BEQEX;
          op_i6 == OP_ADDI:  state_d = S_ADDIEX;
          op_i6 == OP_J:     state_d = S_JEX;
`ifdef MC_CTRL_BNE_EN
          op_i6 == OP_BNE:   state_d = S_BNEEX;
`endif
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = (op_i6 == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: if (rdy) state_d = S_MEMWB;
      S_MEMWR: begin
        if (rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_ADDIWB,
`ifdef MC_CTRL_BNE_EN
      S_BNEEX,
`endif
      S_BEQEX, S_JEX: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mc_out_dec #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE)
  ) u_out_dec (
    .state_i    (state_q),
    .op_i       (op_i6),
    .zero_i     (zero_i),
    .mem_ready_i(mem_ready_i),
    .ctrl_o     (ctrl)
  );

  assign iord_o         = ctrl.iord;
  assign mem_write_o    = ctrl.mem_write;
  assign ir_write_o     = ctrl.ir_write;
  assign reg_dst_rtrd_o = ctrl.reg_dst;
  assign alu_wreg_o     = ctrl.alu_wreg;
  assign enable_wreg_o  = ctrl.enable_wreg;
  assign alu_src_a_o    = ctrl.alu_src_a;
  assign alu_src_b_o2   = ctrl.alu_src_b;
  assign alu_op_o2      = ctrl.alu_op;
  assign pc_src_o2      = ctrl.pc_src;
  assign pc_en_o        = ctrl.pc_en;
  assign illegal_op_o   = ctrl.illegal;
  assign instr_cnt_o    = cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (4-bit counter to reach wrap).
// Honours MC_CTRL_BNE_EN when defined for the build.
module tb_mc_controller;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [5:0] op_i6;
  logic       zero_i;
  logic       mem_ready_i;
  logic       iord_o, mem_write_o, ir_write_o;
  logic       reg_dst_rtrd_o, alu_wreg_o, enable_wreg_o;
  logic       alu_src_a_o, pc_en_o, illegal_op_o;
  logic [1:0] alu_src_b_o2, alu_op_o2, pc_src_o2;
  logic [3:0] instr_cnt_o;

  int ntests = 0;
  int nfail  = 0;
  int mw_cyc;
  int guard;
  logic [3:0] exp_cnt;

  always #5 clk_i = ~clk_i;

  mc_controller #(
    .MEM_HANDSHAKE(1),
    .CNT_W        (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .op_i6         (op_i6),
    .zero_i        (zero_i),
    .mem_ready_i   (mem_ready_i),
    .iord_o        (iord_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_dst_rtrd_o(reg_dst_rtrd_o),
    .alu_wreg_o    (alu_wreg_o),
    .enable_wreg_o (enable_wreg_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o2  (alu_src_b_o2),
    .alu_op_o2     (alu_op_o2),
    .pc_src_o2     (pc_src_o2),
    .pc_en_o       (pc_en_o),
    .illegal_op_o  (illegal_op_o),
    .instr_cnt_o   (instr_cnt_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    op_i6       = 6'b000000;
    zero_i      = 1'b0;
    mem_ready_i = 1'b1;
    #2;
    chk("rst_irw", 32'(ir_write_o), 32'd1);
    chk("rst_wreg", 32'(enable_wreg_o), 32'd0);
    chk("rst_srcb", 32'(alu_src_b_o2), 32'd1);
    chk("rst_cnt", 32'(instr_cnt_o), 32'd0);
    tick();
    rst_ni = 1'b1;

    // R-type interrupted by reset in RTYPEEX
    tick();
    chk("r_dec_srcb", 32'(alu_src_b_o2), 32'd3);
    tick();
    chk("r_ex_aluop", 32'(alu_op_o2), 32'd2);
    chk("r_ex_srca", 32'(alu_src_a_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_irw", 32'(ir_write_o), 32'd1);
    chk("midrst_wreg", 32'(enable_wreg_o), 32'd0);
    chk("midrst_aluop", 32'(alu_op_o2), 32'd0);
    chk("midrst_cnt", 32'(instr_cnt_o), 32'd0);
    tick();
    rst_ni = 1'b1;

    // full R-type
    tick();
    tick();
    tick();
    chk("r_wb_wreg", 32'(enable_wreg_o), 32'd1);
    chk("r_wb_dst", 32'(reg_dst_rtrd_o), 32'd1);
    chk("r_wb_src", 32'(alu_wreg_o), 32'd0);
    tick();
    chk("r_cnt", 32'(instr_cnt_o), 32'd1);

    // LW: 5 cycles
    op_i6 = 6'b100011;
    chk("lw_c1_irw", 32'(ir_write_o), 32'd1);
    chk("lw_c1_pcen", 32'(pc_en_o), 32'd1);
    chk("lw_c1_wreg", 32'(enable_wreg_o), 32'd0);
    tick();
    chk("lw_c2_wreg", 32'(enable_wreg_o), 32'd0);
    tick();
    chk("lw_c3_srcb", 32'(alu_src_b_o2), 32'd2);
    chk("lw_c3_wreg", 32'(enable_wreg_o), 32'd0);
    tick();
    chk("lw_c4_iord", 32'(iord_o), 32'd1);
    chk("lw_c4_wreg", 32'(enable_wreg_o), 32'd0);
    tick();
    chk("lw_c5_wreg", 32'(enable_wreg_o), 32'd1);
    chk("lw_c5_awr", 32'(alu_wreg_o), 32'd1);
    chk("lw_c5_dst", 32'(reg_dst_rtrd_o), 32'd0);
    chk("lw_c5_cnt", 32'(instr_cnt_o), 32'd1);
    tick();
    chk("lw_cnt", 32'(instr_cnt_o), 32'd2);
    chk("lw_fetch_irw", 32'(ir_write_o), 32'd1);

    // FETCH stall
    mem_ready_i = 1'b0;
    #1;
    chk("fstall_irw", 32'(ir_write_o), 32'd0);
    chk("fstall_pcen", 32'(pc_en_o), 32'd0);
    tick();
    chk("fstall_hold", 32'(alu_src_b_o2), 32'd1);
    mem_ready_i = 1'b1;

    // SW with 3 wait cycles in MEMWR
    op_i6 = 6'b101011;
    tick();
    tick();
    mw_cyc = 0;
    guard  = 0;
    tick();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_write_o === 1'b1) mw_cyc++;
      chk("sw_wait_iord", 32'(iord_o), 32'd1);
      tick();
    end
    mem_ready_i = 1'b1;
    #1;
    if (mem_write_o === 1'b1) mw_cyc++;
    chk("sw_ack_iord", 32'(iord_o), 32'd1);
    tick();
    chk("sw_mw_cycles", 32'(mw_cyc), 32'd4);
    chk("sw_mw_drop", 32'(mem_write_o), 32'd0);
    chk("sw_cnt", 32'(instr_cnt_o), 32'd3);

    // BEQ taken / not taken
    op_i6  = 6'b000100;
    zero_i = 1'b1;
    tick();
    tick();
    chk("beq_t_pcen", 32'(pc_en_o), 32'd1);
    chk("beq_t_pcsrc", 32'(pc_src_o2), 32'd1);
    chk("beq_t_aluop", 32'(alu_op_o2), 32'd1);
    tick();
    zero_i = 1'b0;
    tick();
    tick();
    chk("beq_n_pcen", 32'(pc_en_o), 32'd0);
    tick();
    chk("beq_cnt", 32'(instr_cnt_o), 32'd5);

    // ADDI: 4 cycles
    op_i6 = 6'b001000;
    tick();
    tick();
    chk("addi_ex_srcb", 32'(alu_src_b_o2), 32'd2);
    tick();
    chk("addi_wb_wreg", 32'(enable_wreg_o), 32'd1);
    chk("addi_wb_src", 32'(alu_wreg_o), 32'd0);
    tick();
    chk("addi_cnt", 32'(instr_cnt_o), 32'd6);

    // illegal opcode
    op_i6 = 6'b111111;
    tick();
    chk("ill_pulse", 32'(illegal_op_o), 32'd1);
    chk("ill_wreg", 32'(enable_wreg_o), 32'd0);
    chk("ill_mw", 32'(mem_write_o), 32'd0);
    tick();
    chk("ill_clear", 32'(illegal_op_o), 32'd0);
    chk("ill_fetch", 32'(ir_write_o), 32'd1);
    chk("ill_cnt", 32'(instr_cnt_o), 32'd6);

    // BNE
    op_i6  = 6'b000101;
    zero_i = 1'b0;
    tick();
`ifdef MC_CTRL_BNE_EN
    chk("bne_dec_ill", 32'(illegal_op_o), 32'd0);
    tick();
    chk("bne_pcen", 32'(pc_en_o), 32'd1);
    chk("bne_pcsrc", 32'(pc_src_o2), 32'd1);
    tick();
    exp_cnt = 4'd7;
`else
    chk("bne_ill", 32'(illegal_op_o), 32'd1);
    tick();
    chk("bne_fetch", 32'(ir_write_o), 32'd1);
    exp_cnt = 4'd6;
`endif
    chk("bne_cnt", 32'(instr_cnt_o), 32'(exp_cnt));

    // J instructions up to and across the counter wrap
    op_i6 = 6'b000010;
    while (exp_cnt != 4'hF && guard < 20) begin
      tick();
      tick();
      chk("j_pcsrc", 32'(pc_src_o2), 32'd2);
      chk("j_pcen", 32'(pc_en_o), 32'd1);
      tick();
      exp_cnt = exp_cnt + 4'd1;
      guard++;
      chk("j_cnt", 32'(instr_cnt_o), 32'(exp_cnt));
    end
    tick();
    tick();
    tick();
    chk("wrap_cnt", 32'(instr_cnt_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
